// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline front end.
// Also holds the IF/ID pipeline register layout.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_INC    = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               misalign;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc4: '0, instr: NOP_INSTR, valid: 1'b0, misalign: 1'b0};

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: stall hold, then a fresh redirect, then a deferred redirect,
// then sequential increment.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic              stall,
    input  logic              pending,
    input  logic [ADDR_W-1:0] pend_target,
    input  logic              req,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect_applied
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        next_pc          = pc;
        redirect_applied = 1'b0;
        if (!stall) begin
            if (req) begin
                // A redirect resolved this cycle is newer than one deferred by a stall.
                next_pc          = target;
                redirect_applied = 1'b1;
            end else if (pending) begin
                next_pc          = pend_target;
                redirect_applied = 1'b1;
            end else begin
                next_pc = pc + PC_INC;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect deferral across stalls, and the
// IF/ID pipeline register feeding decode.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter bit                DELAY_SLOT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               if_id_misalign
);

    logic              req;
    logic [ADDR_W-1:0] target;
    logic              pending;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect_applied;
    if_id_t            if_id;

    assign req    = branch_taken | jump;
    assign target = branch_taken ? branch_target : jump_target;

    pc_next_sel u_pc_next_sel (
        .stall            (stall),
        .pending          (pending),
        .pend_target      (pend_target),
        .req              (req),
        .target           (target),
        .pc               (pc),
        .next_pc          (next_pc),
        .redirect_applied (redirect_applied)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pend_target <= '0;
            if_id       <= IF_ID_BUBBLE;
        end else begin
            pc <= next_pc;
            if (stall) begin
                if (req) begin
                    pending     <= 1'b1;
                    pend_target <= target;
                end
            end else begin
                pending <= 1'b0;
                if (!DELAY_SLOT && redirect_applied) begin
                    if_id <= IF_ID_BUBBLE;
                end else begin
                    if_id <= '{pc4: pc + PC_INC, instr: imem_rdata, valid: 1'b1,
                               misalign: (pc[1:0] != 2'b00)};
                end
            end
        end
    end

    assign imem_addr      = pc;
    assign if_id_pc4      = if_id.pc4;
    assign if_id_instr    = if_id.instr;
    assign if_id_valid    = if_id.valid;
    assign if_id_misalign = if_id.misalign;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: two instances (delay slot on/off) share stimulus and are
// compared against a cycle-level reference model plus directed expectations.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;

    logic [31:0] imem_addr   [2];
    logic [31:0] imem_rdata  [2];
    logic [31:0] pc          [2];
    logic [31:0] if_id_pc4   [2];
    logic [31:0] if_id_instr [2];
    logic        if_id_valid [2];
    logic        if_id_misalign [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: address 0 holds 0x2001_0005, the rest a hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2001_0005 ^ (a * 32'h9E37_79B9);
    endfunction

    assign imem_rdata[0] = mem_word(imem_addr[0]);
    assign imem_rdata[1] = mem_word(imem_addr[1]);

    if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) dut_ds (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]), .pc(pc[0]),
        .if_id_pc4(if_id_pc4[0]), .if_id_instr(if_id_instr[0]),
        .if_id_valid(if_id_valid[0]), .if_id_misalign(if_id_misalign[0])
    );

    if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) dut_sq (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]), .pc(pc[1]),
        .if_id_pc4(if_id_pc4[1]), .if_id_instr(if_id_instr[1]),
        .if_id_valid(if_id_valid[1]), .if_id_misalign(if_id_misalign[1])
    );

    // Reference model state, index 0 = delay slot kept, index 1 = redirect squashes IF/ID.
    logic [31:0] m_pc [2];
    logic        m_pend [2];
    logic [31:0] m_ptgt [2];
    logic [31:0] m_pc4 [2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_mis [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        logic        req;
        logic [31:0] tgt;
        logic        redirected;
        req = branch_taken | jump;
        tgt = branch_taken ? branch_target : jump_target;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_ptgt[k] = 32'h0;
                m_pc4[k] = 32'h0; m_instr[k] = 32'h0; m_valid[k] = 1'b0; m_mis[k] = 1'b0;
            end else if (stall) begin
                if (req) begin
                    m_pend[k] = 1'b1;
                    m_ptgt[k] = tgt;
                end
            end else begin
                redirected = req || m_pend[k];
                if (k == 1 && redirected) begin
                    m_pc4[k] = 32'h0; m_instr[k] = 32'h0; m_valid[k] = 1'b0; m_mis[k] = 1'b0;
                end else begin
                    m_pc4[k]   = m_pc[k] + 32'd4;
                    m_instr[k] = mem_word(m_pc[k]);
                    m_valid[k] = 1'b1;
                    m_mis[k]   = (m_pc[k] % 4) != 0;
                end
                if (req)          m_pc[k] = tgt;
                else if (m_pend[k]) m_pc[k] = m_ptgt[k];
                else              m_pc[k] = m_pc[k] + 32'd4;
                m_pend[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_model(input string ctx);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s[%0d].pc", ctx, k), pc[k], m_pc[k]);
            check($sformatf("%s[%0d].imem_addr", ctx, k), imem_addr[k], m_pc[k]);
            check($sformatf("%s[%0d].pc4", ctx, k), if_id_pc4[k], m_pc4[k]);
            check($sformatf("%s[%0d].instr", ctx, k), if_id_instr[k], m_instr[k]);
            check($sformatf("%s[%0d].valid", ctx, k), {31'b0, if_id_valid[k]}, {31'b0, m_valid[k]});
            check($sformatf("%s[%0d].misalign", ctx, k), {31'b0, if_id_misalign[k]}, {31'b0, m_mis[k]});
        end
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(ctx);
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    endtask

    logic [31:0] frozen_instr;
    logic [31:0] frozen_pc4;

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_ptgt[k] = 32'h0;
            m_pc4[k] = 32'h0; m_instr[k] = 32'h0; m_valid[k] = 1'b0; m_mis[k] = 1'b0;
        end
        #2;

        // Reset held for two edges.
        tick("reset");
        tick("reset");
        check("reset_pc", pc[0], 32'h0);
        check("reset_valid", {31'b0, if_id_valid[0]}, 32'h0);
        check("reset_instr", if_id_instr[1], 32'h0);

        idle();
        tick("run");
        check("first_pc", pc[0], 32'h4);
        check("first_pc4", if_id_pc4[0], 32'h4);
        check("first_instr", if_id_instr[0], 32'h2001_0005);
        check("first_valid", {31'b0, if_id_valid[0]}, 32'h1);
        tick("run");
        check("seq_pc8", pc[0], 32'h8);
        tick("run");
        check("seq_pcC", pc[1], 32'hC);

        // Branch at 0x0C to 0x40: delay slot survives only in the DELAY_SLOT=1 instance.
        branch_taken = 1'b1; branch_target = 32'h40;
        tick("branch");
        check("branch_pc", pc[0], 32'h40);
        check("branch_ds_instr", if_id_instr[0], mem_word(32'hC));
        check("branch_ds_valid", {31'b0, if_id_valid[0]}, 32'h1);
        check("branch_sq_valid", {31'b0, if_id_valid[1]}, 32'h0);

        // Jump back to 0x10, then stall there for three cycles.
        idle(); jump = 1'b1; jump_target = 32'h10;
        tick("jump10");
        idle();
        tick("pre_stall");
        check("pre_stall_pc", pc[0], 32'h14);
        idle(); jump = 1'b1; jump_target = 32'h10;
        tick("jump10b");
        idle(); stall = 1'b1;
        frozen_instr = if_id_instr[0];
        frozen_pc4   = if_id_pc4[0];
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall_pc", pc[0], 32'h10);
            check("stall_instr_frozen", if_id_instr[0], frozen_instr);
            check("stall_pc4_frozen", if_id_pc4[0], frozen_pc4);
        end
        idle();
        tick("unstall");
        check("unstall_pc", pc[0], 32'h14);

        // Branch raised during a stall is deferred until the stall drops.
        jump = 1'b1; jump_target = 32'h20;
        tick("jump20");
        idle(); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        tick("stall_br");
        check("stall_br_hold", pc[0], 32'h20);
        idle(); stall = 1'b1;
        tick("stall_br2");
        check("stall_br_hold2", pc[1], 32'h20);
        idle();
        tick("pend_apply");
        check("pend_apply_pc", pc[0], 32'h80);
        check("pend_sq_valid", {31'b0, if_id_valid[1]}, 32'h0);
        tick("pend_cleared");
        check("pend_cleared_pc", pc[0], 32'h84);

        // Jump with squash: IF/ID bubble in the DELAY_SLOT=0 instance.
        jump = 1'b1; jump_target = 32'h100;
        tick("jump100");
        check("jump100_pc", pc[1], 32'h100);
        check("jump100_sq_instr", if_id_instr[1], 32'h0);
        check("jump100_sq_valid", {31'b0, if_id_valid[1]}, 32'h0);

        // Wrap from the top of the address space.
        idle(); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick("to_top");
        idle();
        tick("wrap");
        check("wrap_pc", pc[0], 32'h0);
        check("wrap_pc4", if_id_pc4[0], 32'h0);

        // Misaligned target is accepted and flagged one cycle later.
        branch_taken = 1'b1; branch_target = 32'h42;
        tick("mis_br");
        check("mis_pc", pc[0], 32'h42);
        idle();
        tick("mis_flag");
        check("mis_flag_ds", {31'b0, if_id_misalign[0]}, 32'h1);
        check("mis_flag_sq", {31'b0, if_id_misalign[1]}, 32'h1);

        // Simultaneous branch and jump: branch wins.
        branch_taken = 1'b1; branch_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
        tick("both");
        check("both_pc", pc[0], 32'h200);

        // Reset while a redirect is pending discards it.
        idle(); stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
        tick("pend_then_rst");
        idle(); rst = 1'b1; stall = 1'b1;
        tick("rst_mid_stall");
        idle();
        tick("after_rst");
        check("after_rst_pc", pc[0], 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 49) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_target = ($urandom_range(0, 9) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            jump_target   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + ($urandom() & 32'h7)
                                                         : ($urandom() & 32'hFFFF_FFFC);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
